fpu_writeback_arbiter: RTL and testbench

//  Receiving end of the FPU write-back interface (enable/addr/data/float, fixed latency).

---
 rtl/fpu_writeback_arbiter.sv | 128 ++++++++++++
 tb/tb_fpu_writeback_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_writeback_arbiter.sv
// Merges FPU and integer results onto the single register-file write port, with an FPU result FIFO, issue credits and a float RAW scoreboard.
// Optional FPU_WB_BYPASS_EN: an FPU result with the FIFO empty and no integer write goes straight to the port.
module fpu_writeback_arbiter #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FPU_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        issue_stall,
  input  logic        fpu_enable,
  input  logic [4:0]  fpu_addr,
  input  logic [31:0] fpu_data,
  input  logic        fpu_float,
  input  logic        int_enable,
  input  logic [4:0]  int_addr,
  input  logic [31:0] int_data,
  input  logic        int_float,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic        rs_hazard,
  output logic        rt_hazard,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        rf_float
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = AW + 2;

  logic [PW-1:0]      wr_ptr, rd_ptr, count;
  logic [4:0]         mem_addr [DEPTH];
  logic [31:0]        mem_data [DEPTH];
  logic [FPU_LAT-1:0] lat_sr;
  logic [SW-1:0]      inflight;
  logic [31:0]        pending, pending_nxt;
  logic               rf_fpu;
  logic               empty, full, accept, fpu_valid, sel_pop, sel_byp, push;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Issues still travelling through the FPU pipeline hold a credit each.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(FPU_LAT); i++) inflight = inflight + SW'(lat_sr[i]);
  end

  assign issue_stall = (SW'(count) + inflight) >= SW'(DEPTH);
  assign accept      = issue_valid & ~issue_stall;

  // A result is only genuine if it matches an accepted issue; stale ones after reset are dropped.
  assign fpu_valid = fpu_enable & lat_sr[FPU_LAT-1];
  assign sel_pop   = ~int_enable & ~empty;

`ifdef FPU_WB_BYPASS_EN
  assign sel_byp = ~int_enable & empty & fpu_valid;
`else
  logic unused_fpu_float;
  assign unused_fpu_float = fpu_float;
  assign sel_byp = 1'b0;
`endif

  assign push = fpu_valid & ~sel_byp;

  assign rs_hazard = pending[rs_addr];
  assign rt_hazard = pending[rt_addr];

  // Clear follows the registered FPU write; a same-cycle issue to that address re-sets it.
  always_comb begin
    pending_nxt = pending;
    if (rf_we && rf_fpu) pending_nxt[rf_addr] = 1'b0;
    if (accept)          pending_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[AW-1:0]] <= fpu_addr;
      mem_data[wr_ptr[AW-1:0]] <= fpu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lat_sr   <= '0;
      pending  <= '0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      rf_float <= 1'b0;
      rf_fpu   <= 1'b0;
    end else begin
      lat_sr  <= (lat_sr << 1) | FPU_LAT'(accept);
      pending <= pending_nxt;
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (sel_pop) rd_ptr <= rd_ptr + PW'(1);
      if (int_enable) begin
        rf_we    <= 1'b1;
        rf_addr  <= int_addr;
        rf_data  <= int_data;
        rf_float <= int_float;
        rf_fpu   <= 1'b0;
      end else if (sel_pop) begin
        rf_we    <= 1'b1;
        rf_addr  <= mem_addr[rd_ptr[AW-1:0]];
        rf_data  <= mem_data[rd_ptr[AW-1:0]];
        rf_float <= 1'b1;
        rf_fpu   <= 1'b1;
      end else if (sel_byp) begin
        rf_we    <= 1'b1;
        rf_addr  <= fpu_addr;
        rf_data  <= fpu_data;
        rf_float <= fpu_float;
        rf_fpu   <= 1'b1;
      end else begin
        rf_we  <= 1'b0;
        rf_fpu <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_writeback_arbiter.sv
// Directed bench for fpu_writeback_arbiter; a fixed-latency FPU model returns results for accepted issues.
module tb_fpu_writeback_arbiter;

`ifdef FPU_WB_BYPASS_EN
  localparam int LB = 0;
`else
  localparam int LB = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic [31:0] issue_data = '0;
  logic        issue_stall;
  logic        fpu_enable;
  logic [4:0]  fpu_addr;
  logic [31:0] fpu_data;
  logic        int_enable = 1'b0;
  logic [4:0]  int_addr = '0;
  logic [31:0] int_data = '0;
  logic        int_float = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        rs_hazard, rt_hazard;
  logic        rf_we, rf_float;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  logic        man_en = 1'b0;
  logic [4:0]  man_addr = '0;
  logic [31:0] man_data = '0;
  logic [2:0]  pv = '0;
  logic [4:0]  pa [3];
  logic [31:0] pd [3];
  logic        overflow_seen = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // FPU model: an accepted issue returns its result three cycles later; it is not reset.
  always @(posedge clk) begin
    pv    <= {pv[1:0], issue_valid & ~issue_stall};
    pa[0] <= issue_addr;
    pd[0] <= issue_data;
    pa[1] <= pa[0];
    pd[1] <= pd[0];
    pa[2] <= pa[1];
    pd[2] <= pd[1];
  end

  assign fpu_enable = pv[2] | man_en;
  assign fpu_addr   = pv[2] ? pa[2] : man_addr;
  assign fpu_data   = pv[2] ? pd[2] : man_data;

  always @(posedge clk) begin
    if (!rst && dut.push && dut.full) overflow_seen <= 1'b1;
  end

  fpu_writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_stall(issue_stall),
    .fpu_enable(fpu_enable), .fpu_addr(fpu_addr), .fpu_data(fpu_data), .fpu_float(1'b1),
    .int_enable(int_enable), .int_addr(int_addr), .int_data(int_data), .int_float(int_float),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_hazard(rs_hazard), .rt_hazard(rt_hazard),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_float(rf_float)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int issued;
    int got;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_float", rf_float, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_haz", rs_hazard, 0);

    // 1) Single FPU result, no integer traffic
    issue_valid = 1'b1; issue_addr = 5'd7; issue_data = 32'h3F80_0000;
    chk("t1_stall", issue_stall, 0);
    tick();
    issue_valid = 1'b0;
    repeat (2 + LB) tick();
    chk("t1_early", rf_we, 0);
    tick();
    chk("t1_we", rf_we, 1);
    chk("t1_addr", rf_addr, 7);
    chk("t1_data", rf_data, 32'h3F80_0000);
    chk("t1_float", rf_float, 1);
    tick();
    chk("t1_after", rf_we, 0);

    // 2) Collision: integer first, FPU next cycle from the FIFO
    issue_valid = 1'b1; issue_addr = 5'd4; issue_data = 32'h4000_0000;
    tick();
    issue_valid = 1'b0;
    repeat (2) tick();
    int_enable = 1'b1; int_addr = 5'd3; int_data = 32'd5; int_float = 1'b0;
    tick();
    int_enable = 1'b0;
    chk("t2_int_we", rf_we, 1);
    chk("t2_int_addr", rf_addr, 3);
    chk("t2_int_data", rf_data, 5);
    chk("t2_int_float", rf_float, 0);
    tick();
    chk("t2_fpu_we", rf_we, 1);
    chk("t2_fpu_addr", rf_addr, 4);
    chk("t2_fpu_data", rf_data, 32'h4000_0000);
    chk("t2_fpu_float", rf_float, 1);
    tick();
    chk("t2_idle", rf_we, 0);

    // 3) Credit stall under 10 cycles of integer traffic
    for (int i = 0; i < 10; i++) begin
      int_enable = 1'b1; int_addr = 5'd2; int_data = 32'(i); int_float = 1'b0;
      issue_valid = (i < 4);
      issue_addr = 5'(10 + i);
      issue_data = 32'h100 + 32'(i);
      if (i < 4) chk("t3_credit", issue_stall, 0);
      if (i == 4 || i == 9) chk("t3_stalled", issue_stall, 1);
      tick();
    end
    int_enable = 1'b0; issue_valid = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      chk("t3_we", rf_we, 1);
      chk("t3_addr", rf_addr, 10 + j);
      chk("t3_data", rf_data, 32'h100 + 32'(j));
      chk("t3_float", rf_float, 1);
      tick();
    end
    chk("t3_idle", rf_we, 0);
    chk("t3_unstall", issue_stall, 0);

    // 4) Scoreboard hazard on f9, then re-issue in the clearing cycle
    rs_addr = 5'd9; rt_addr = 5'd8;
    issue_valid = 1'b1; issue_addr = 5'd9; issue_data = 32'h4040_0000;
    chk("t4_pre", rs_hazard, 0);
    tick();
    issue_valid = 1'b0;
    chk("t4_set", rs_hazard, 1);
    chk("t4_other", rt_hazard, 0);
    repeat (3 + LB) tick();
    chk("t4_wr_we", rf_we, 1);
    chk("t4_wr_addr", rf_addr, 9);
    chk("t4_wr_haz", rs_hazard, 1);
    tick();
    chk("t4_clear", rs_hazard, 0);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    repeat (3 + LB) tick();
    chk("t4b_wr_we", rf_we, 1);
    chk("t4b_wr_addr", rf_addr, 9);
    issue_valid = 1'b1; issue_addr = 5'd9; issue_data = 32'h4080_0000;
    tick();
    issue_valid = 1'b0;
    chk("t4b_held", rs_hazard, 1);
    repeat (3 + LB) tick();
    chk("t4c_wr_we", rf_we, 1);
    chk("t4c_wr_data", rf_data, 32'h4080_0000);
    chk("t4c_wr_haz", rs_hazard, 1);
    tick();
    chk("t4c_clear", rs_hazard, 0);

    // 5) Stream 12 results through the FIFO with toggling integer writes
    issued = 0;
    got = 0;
    for (int cyc = 0; cyc < 300 && got < 12; cyc++) begin
      int_enable = cyc[0]; int_addr = 5'd1; int_data = 32'(cyc); int_float = 1'b0;
      issue_valid = (issued < 12);
      issue_addr = 5'(16 + issued);
      issue_data = 32'hA000_0000 + 32'(issued);
      if (rf_we && rf_float) begin
        chk("t5_addr", rf_addr, 16 + got);
        chk("t5_data", rf_data, 32'hA000_0000 + 32'(got));
        got++;
      end
      if (issue_valid && !issue_stall) issued++;
      tick();
    end
    int_enable = 1'b0; issue_valid = 1'b0;
    chk("t5_got", got, 12);
    chk("t5_issued", issued, 12);
    repeat (2) tick();
    chk("t5_idle", rf_we, 0);
    chk("t5_stall", issue_stall, 0);

    // 6) Reset with two queued results and one still in the FPU
    rs_addr = 5'd21; rt_addr = 5'd23;
    int_enable = 1'b1; int_addr = 5'd2; int_data = 32'd0; int_float = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd21; issue_data = 32'd1;
    tick();
    issue_addr = 5'd22; issue_data = 32'd2;
    tick();
    issue_valid = 1'b0;
    tick();
    issue_valid = 1'b1; issue_addr = 5'd23; issue_data = 32'd3;
    tick();
    issue_valid = 1'b0;
    tick();
    chk("t6_haz_pre", rs_hazard, 1);
    rst = 1'b1; int_enable = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_we", rf_we, 0);
    chk("t6_rs", rs_hazard, 0);
    chk("t6_rt", rt_hazard, 0);
    chk("t6_stall", issue_stall, 0);
    tick();
    man_en = 1'b1; man_addr = 5'd25; man_data = 32'hDEAD_BEEF;
    chk("t6_late1", rf_we, 0);
    tick();
    man_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t6_nowr", rf_we, 0);
      tick();
    end
    chk("t6_stall_end", issue_stall, 0);
    chk("no_overflow", overflow_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
